// File: rtl/wb_stream_pkg.sv
// Shared constants and state encoding for the Wishbone stream reader master.
package wb_stream_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INC     = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BURST,
      ST_ERROR
   } state_e;

endpackage

// File: rtl/wb_stream_reader_fifo.sv
// Synchronous show-ahead FIFO: the head word is visible combinationally
// from the read pointer, so a pop and the next beat's data line up.
module wb_stream_reader_fifo #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [DW-1:0] din_i,
   input  logic          pop_i,
   output logic [DW-1:0] dout_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   level_o
);
   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          do_push, do_pop;

   assign full_o  = (level_q == (AW+1)'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign dout_o  = mem[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Pointer and level update; simultaneous push and pop leaves level unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_d = level_q + 1'b1;
      else if (!do_push && do_pop) level_d = level_q - 1'b1;
   end

   // Pointer registers; reset flushes the FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/wb_stream_reader_master.sv
// Stream-to-memory DMA: buffers incoming stream words and writes them to a
// circular buffer using incrementing Wishbone bursts.
module wb_stream_reader_master
   import wb_stream_pkg::*;
#(
   parameter int WB_AW   = 32,
   parameter int WB_DW   = 32,
   parameter int FIFO_AW = 5
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   output logic [WB_AW-1:0]   wbm_adr_o,
   output logic [WB_DW-1:0]   wbm_dat_o,
   output logic [WB_DW/8-1:0] wbm_sel_o,
   output logic               wbm_we_o,
   output logic               wbm_cyc_o,
   output logic               wbm_stb_o,
   output logic [2:0]         wbm_cti_o,
   output logic [1:0]         wbm_bte_o,
   input  logic               wbm_ack_i,
   input  logic               wbm_err_i,
   input  logic [WB_DW-1:0]   stream_s_data_i,
   input  logic               stream_s_valid_i,
   output logic               stream_s_ready_o,
   input  logic               enable,
   input  logic [WB_AW-1:0]   start_adr,
   input  logic [WB_AW-1:0]   buf_size,
   input  logic [WB_AW-1:0]   burst_size,
   output logic               irq_o,
   output logic               err_o
);
   localparam logic [WB_AW-1:0] STRIDE = WB_AW'(WB_DW / 8);

   state_e             state_q, state_d;
   logic [WB_AW-1:0]   offset_q, offset_d;
   logic [WB_AW-1:0]   adr_q, adr_d;
   logic [WB_AW-1:0]   burst_len_q, burst_len_d;
   logic [WB_AW-1:0]   buf_len_q, buf_len_d;
   logic [WB_AW-1:0]   beat_cnt_q, beat_cnt_d;
   logic [2:0]         cti_q, cti_d;
   logic               cyc_q, cyc_d;
   logic               irq_q, irq_d;
   logic               err_q, err_d;

   logic               fifo_full, fifo_empty, fifo_pop;
   logic [FIFO_AW:0]   fifo_level;
   logic [WB_AW-1:0]   next_off;
   logic               last_beat;

   wb_stream_reader_fifo #(.DW(WB_DW), .AW(FIFO_AW)) u_fifo (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .push_i  (stream_s_valid_i && stream_s_ready_o),
      .din_i   (stream_s_data_i),
      .pop_i   (fifo_pop),
      .dout_o  (wbm_dat_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign stream_s_ready_o = !fifo_full && !wb_rst_i;
   assign wbm_adr_o = adr_q;
   assign wbm_sel_o = '1;
   assign wbm_we_o  = cyc_q;
   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = cyc_q;
   assign wbm_cti_o = cti_q;
   assign wbm_bte_o = BTE_LINEAR;
   assign irq_o     = irq_q;
   assign err_o     = err_q;
   assign next_off  = offset_q + burst_len_q;
   assign last_beat = (beat_cnt_q == burst_len_q - 1'b1);

   // Next-state and output decode; config is latched only when a burst starts.
   always_comb begin
      state_d     = state_q;
      offset_d    = offset_q;
      adr_d       = adr_q;
      burst_len_d = burst_len_q;
      buf_len_d   = buf_len_q;
      beat_cnt_d  = beat_cnt_q;
      cti_d       = cti_q;
      cyc_d       = cyc_q;
      irq_d       = 1'b0;
      err_d       = err_q;
      fifo_pop    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!enable) begin
               offset_d = '0;
            end else if (burst_size != '0 && WB_AW'(fifo_level) >= burst_size) begin
               burst_len_d = burst_size;
               buf_len_d   = buf_size;
               beat_cnt_d  = '0;
               adr_d       = start_adr + offset_q * STRIDE;
               cti_d       = (burst_size == WB_AW'(1)) ? CTI_EOB : CTI_INC;
               cyc_d       = 1'b1;
               state_d     = ST_BURST;
            end
         end
         ST_BURST: begin
            if (wbm_err_i) begin
               // Faulting word stays in the FIFO.
               cyc_d   = 1'b0;
               cti_d   = CTI_CLASSIC;
               err_d   = 1'b1;
               state_d = ST_ERROR;
            end else if (wbm_ack_i) begin
               fifo_pop   = 1'b1;
               adr_d      = adr_q + STRIDE;
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (last_beat) begin
                  cyc_d   = 1'b0;
                  cti_d   = CTI_CLASSIC;
                  state_d = ST_IDLE;
                  if (next_off >= buf_len_q) begin
                     offset_d = '0;
                     irq_d    = 1'b1;
                  end else begin
                     offset_d = next_off;
                  end
               end else if (beat_cnt_q + 1'b1 == burst_len_q - 1'b1) begin
                  cti_d = CTI_EOB;
               end
            end
         end
         ST_ERROR: begin
            if (!enable) begin
               err_d    = 1'b0;
               offset_d = '0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control registers.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q     <= ST_IDLE;
         offset_q    <= '0;
         adr_q       <= '0;
         burst_len_q <= '0;
         buf_len_q   <= '0;
         beat_cnt_q  <= '0;
         cti_q       <= CTI_CLASSIC;
         cyc_q       <= 1'b0;
         irq_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         offset_q    <= offset_d;
         adr_q       <= adr_d;
         burst_len_q <= burst_len_d;
         buf_len_q   <= buf_len_d;
         beat_cnt_q  <= beat_cnt_d;
         cti_q       <= cti_d;
         cyc_q       <= cyc_d;
         irq_q       <= irq_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_wb_stream_reader_master.sv
// Randomized bench: a queue-based memory-write model predicts every beat's
// address, data and cycle type, plus irq/err/ready behaviour.
module tb_wb_stream_reader_master;
   localparam int DEPTH = 32;

   logic        clk, rst;
   logic [31:0] adr, dat;
   logic [3:0]  sel;
   logic        we, cyc, stb, ack, err;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic [31:0] sdata;
   logic        valid, ready, enable;
   logic [31:0] start_adr, buf_size, burst_size;
   logic        irq, err_o;

   wb_stream_reader_master #(.WB_AW(32), .WB_DW(32), .FIFO_AW(5)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_sel_o(sel), .wbm_we_o(we),
      .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_cti_o(cti), .wbm_bte_o(bte),
      .wbm_ack_i(ack), .wbm_err_i(err),
      .stream_s_data_i(sdata), .stream_s_valid_i(valid), .stream_s_ready_o(ready),
      .enable(enable), .start_adr(start_adr), .buf_size(buf_size),
      .burst_size(burst_size), .irq_o(irq), .err_o(err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0;

   // model state
   logic [31:0] q[$];
   int npush, npop, off, k, bs, bufw, src_left, src_rate, ack_rate, irq_cnt;
   logic [31:0] base;
   bit in_burst, irq_exp, err_exp, cyc_low_exp, err_mode, en_cmd;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      npush = 0; npop = 0; off = 0; k = 0;
      in_burst = 0; irq_exp = 0; err_exp = 0; cyc_low_exp = 0; err_mode = 0;
      src_left = 0;
   endtask

   task automatic set_cfg(input logic [31:0] a, input int b, input int s);
      base = a; bufw = b; bs = s;
      start_adr = a; buf_size = 32'(b); burst_size = 32'(s);
   endtask

   // One clock: check what the last edge produced, then drive the next one.
   task automatic cycle();
      @(negedge clk);
      chk("ready", ready, (npush - npop) != DEPTH);
      chk("irq", irq, irq_exp);
      if (irq) irq_cnt++;
      irq_exp = 0;
      chk("err_o", err_o, err_exp);
      chk("stb_eq_cyc", stb, cyc);
      chk("we_eq_cyc", we, cyc);
      if (cyc_low_exp) begin
         chk("cyc_drop", cyc, 0);
         cyc_low_exp = 0;
      end else if (err_exp) begin
         chk("cyc_in_err", cyc, 0);
      end else if (cyc && !in_burst) begin
         chk("level_at_start", (npush - npop) >= bs, 1);
         in_burst = 1;
         k = 0;
      end
      enable = en_cmd;
      if (!en_cmd && !in_burst) begin
         off = 0;
         err_exp = 0;
      end
      valid = 0;
      if (src_left > 0 && $urandom_range(99) < src_rate) begin
         valid = 1;
         sdata = $urandom;
      end
      if (valid && ready) begin
         q.push_back(sdata);
         npush++;
         src_left--;
      end
      ack = 0;
      err = 0;
      if (in_burst && cyc) begin
         if (err_mode && k == 1) begin
            err = 1;
            err_mode = 0;
            err_exp = 1;
            cyc_low_exp = 1;
            in_burst = 0;
         end else if ($urandom_range(99) < ack_rate) begin
            ack = 1;
            chk("adr", adr, base + 32'((off + k) * 4));
            chk("cti", cti, (k == bs - 1) ? 3'b111 : 3'b010);
            if (q.size() > 0) begin
               chk("dat", dat, q[0]);
               void'(q.pop_front());
            end else begin
               chk("dat_underflow", q.size(), 1);
            end
            npop++;
            k++;
            if (k == bs) begin
               in_burst = 0;
               cyc_low_exp = 1;
               off += bs;
               if (off >= bufw) begin
                  off = 0;
                  irq_exp = 1;
               end
            end
         end
      end
   endtask

   task automatic drain();
      bit done = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         if (src_left == 0 && npop == npush && !in_burst) done = 1;
         else cycle();
      end
      chk("drain_timeout", done, 1);
      repeat (3) cycle();
   endtask

   task automatic push_words(input int n);
      src_left += n;
   endtask

   initial begin
      rst = 0; enable = 0; valid = 0; sdata = 0; ack = 0; err = 0;
      en_cmd = 0; src_rate = 100; ack_rate = 100; irq_cnt = 0;
      model_clear();
      set_cfg(32'h1000, 8, 4);
      #1 rst = 1;
      #1;
      chk("rst_cyc", cyc, 0); chk("rst_stb", stb, 0); chk("rst_we", we, 0);
      chk("rst_adr", adr, 0); chk("rst_cti", cti, 0); chk("rst_bte", bte, 0);
      chk("rst_irq", irq, 0); chk("rst_err", err_o, 0); chk("rst_sel", sel, 4'hf);
      chk("rst_ready", ready, 0);
      @(negedge clk); @(negedge clk);
      rst = 0;

      // Two bursts of 4 into an 8-word buffer, then wrap.
      en_cmd = 1;
      push_words(8);
      drain();
      chk("irq_cnt_1", irq_cnt, 1);
      push_words(8);
      drain();
      chk("irq_cnt_2", irq_cnt, 2);

      // Single-beat bursts.
      en_cmd = 0; cycle();
      set_cfg(32'h2000, 4, 1);
      en_cmd = 1;
      push_words(6);
      drain();
      chk("irq_cnt_3", irq_cnt, 3);

      // Random source stalls and slave wait states.
      en_cmd = 0; cycle();
      set_cfg(32'h3000, 32, 8);
      en_cmd = 1; src_rate = 40; ack_rate = 50;
      push_words(200);
      drain();

      // Fill the FIFO with the slave stalled, then release.
      src_rate = 100; ack_rate = 0;
      push_words(40);
      repeat (60) cycle();
      chk("full_ready_low", ready, 0);
      ack_rate = 100;
      drain();

      // Bus error on beat 2.
      en_cmd = 0; cycle();
      set_cfg(32'h1000, 8, 4);
      en_cmd = 1; err_mode = 1; ack_rate = 100;
      push_words(8);
      for (int i = 0; i < 100 && !err_exp; i++) cycle();
      chk("err_seen", err_exp, 1);
      repeat (10) cycle();
      chk("err_sticky", err_o, 1);
      en_cmd = 0; cycle();
      en_cmd = 1; cycle();
      chk("err_cleared", err_o, 0);
      push_words(1);
      drain();

      // Asynchronous reset mid-burst.
      ack_rate = 0;
      push_words(8);
      for (int i = 0; i < 100 && !in_burst; i++) cycle();
      chk("burst_before_rst", cyc, 1);
      #2 rst = 1;
      #1;
      chk("arst_cyc", cyc, 0); chk("arst_stb", stb, 0); chk("arst_adr", adr, 0);
      chk("arst_cti", cti, 0); chk("arst_irq", irq, 0); chk("arst_err", err_o, 0);
      chk("arst_ready", ready, 0);
      model_clear();
      valid = 0; ack = 0;
      @(negedge clk);
      rst = 0;
      ack_rate = 100;
      push_words(3);
      repeat (15) cycle();
      chk("no_burst_after_rst", cyc, 0);
      push_words(1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/wb_stream_reader_master.md
# wb_stream_reader_master

Wishbone bus-master DMA engine that is the receive-direction counterpart of the stream writer: it accepts words from an incoming valid/ready stream, buffers them in an internal FIFO and writes them into a circular buffer in system memory using incrementing Wishbone bursts. It sits between a streaming source (e.g. ADC or packet front-end) and the system interconnect. Buffer geometry and enable come from a separate configuration register block.

## Interface
Parameters:
- WB_AW, 32, Wishbone address width (byte addresses)
- WB_DW, 32, Wishbone/stream data width; multiple of 8
- FIFO_AW, 5, log2 of FIFO depth (depth 32)

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  reset: asynchronous, active-high
- wbm_adr_o  out  WB_AW  byte address
- wbm_dat_o  out  WB_DW  write data
- wbm_sel_o  out  WB_DW/8  byte selects, constant all ones
- wbm_we_o  out  1  constant 1 while cyc_o
- wbm_cyc_o / wbm_stb_o  out  1  cycle / strobe
- wbm_cti_o  out  3  cycle type identifier
- wbm_bte_o  out  2  burst type, constant 2'b00 (linear)
- wbm_ack_i / wbm_err_i  in  1  slave responses (rty not supported)
- stream_s_data_i  in  WB_DW  stream data
- stream_s_valid_i  in  1  data valid
- stream_s_ready_o  out  1  FIFO can accept
- enable  in  1  run enable
- start_adr  in  WB_AW  buffer base, word aligned
- buf_size  in  WB_AW  buffer length in words
- burst_size  in  WB_AW  words per burst
- irq_o  out  1  one-cycle pulse on buffer wrap
- err_o  out  1  sticky bus error flag

## Operation
- Stream transfer when valid && ready; ready = !fifo_full (0 during reset).
- States: IDLE, BURST, ERROR.
- IDLE: if !enable, offset cleared to 0. If enable && burst_size != 0 && fifo_level >= burst_size: latch burst_size into burst_len, adr_o = start_adr + offset*(WB_DW/8), cyc/stb = 1, go BURST.
- BURST: dat_o = FIFO head. cti = 3'b010 for all beats except last; last beat (or burst_len == 1) cti = 3'b111. On ack: pop FIFO, adr_o += WB_DW/8, beat_cnt++. On ack of last beat: cyc/stb = 0, cti = 0, offset += burst_len; if new offset >= buf_size, offset = 0 and irq_o pulses; go IDLE.
- err_i during BURST: cyc/stb drop next edge, FIFO word not popped, go ERROR, err_o = 1. ERROR holds until enable = 0, then err_o clears, offset = 0, IDLE. FIFO contents kept.
- enable falling mid-burst: burst completes normally, then IDLE.
- Config (start_adr, buf_size, burst_size) sampled only at burst start. Software guarantees buf_size multiple of burst_size and 1 <= burst_size <= 2^FIFO_AW; burst_size 0 never starts a burst.
- Offset/beat arithmetic is WB_AW-bit unsigned; address wraps modulo 2^WB_AW.

## Timing
- Reset values: cyc, stb, we, adr, dat (don't care), cti, bte, irq, err = 0; sel = all ones; state IDLE; offset 0; FIFO empty.
- Push-to-level latency 1 cycle; burst request asserted on the edge after the level condition is seen (earliest 2 cycles after the burst_size-th word's handshake).
- Zero-wait-state slaves supported: ack every cycle yields one beat per cycle; FIFO head is combinational from read pointer.
- Simultaneous push and pop: level unchanged; push on full ignored (ready low).
- Reset mid-burst: cyc/stb drop immediately (async), FIFO flushed.

## Structure
- Package wb_stream_pkg: CTI constants (CLASSIC 3'b000, INC 3'b010, EOB 3'b111), BTE_LINEAR, state enum.
- Sub-module wb_stream_reader_fifo: synchronous FIFO, depth 2^FIFO_AW, show-ahead read, full/empty/level outputs, async active-high reset.

## Test plan
- burst_size 4, buf_size 8, start_adr 0x1000, 8 words pushed, zero-wait ack -> two bursts at 0x1000 and 0x1010, cti 010,010,010,111, data in order, irq_o one pulse after second burst.
- Continue 8 more words -> writes wrap to 0x1000, second irq pulse.
- burst_size 1 -> single beats with cti 111, address stride 4.
- Slave inserts random wait states, source stalls -> no data loss or duplication; stream_s_ready_o low exactly when 32 words buffered.
- err_i on beat 2 -> cyc drops, err_o = 1, no further bursts until enable toggled low, then err_o = 0 and restart at start_adr.
- wb_rst_i asserted mid-burst -> all outputs reach reset values without a clock edge; FIFO empty after release.
